screen: RTL and testbench

//  Pixel colour generator for the 24-game VGA display (640x480 active).
//  - Renders 12 hex digits from numbers_concat as 7-segment glyphs in a 4-column x 3-row grid.
//  - Takes the current beam position (sx, sy) from the VGA timing block.
//  - Returns the registered RGB332 colour for that pixel.

---
 rtl/screen.sv | 145 ++++++++++++++
 tb/tb_screen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/screen.sv
// 24-game pixel colour generator: 12 hex digits as 7-segment glyphs in a 4x3 grid.
// Registered RGB332 output, fixed 1-cycle latency, no handshake or backpressure.
module screen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int GRID_X0    = 160,
   parameter int GRID_Y0    = 120,
   parameter int CELL_W     = 80,
   parameter int CELL_H     = 80,
   parameter int GLYPH_XOFF = 16,
   parameter int GLYPH_YOFF = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  sx,
   input  logic [9:0]  sy,
   input  logic [47:0] numbers_concat,
   output logic [2:0]  vga_r,
   output logic [2:0]  vga_g,
   output logic [1:0]  vga_b
);

   localparam logic [10:0] H_END  = 11'(H_ACTIVE);
   localparam logic [10:0] V_END  = 11'(V_ACTIVE);
   localparam logic [10:0] X0     = 11'(GRID_X0);
   localparam logic [10:0] Y0     = 11'(GRID_Y0);
   localparam logic [10:0] X_END  = 11'(GRID_X0 + 4 * CELL_W);
   localparam logic [10:0] Y_END  = 11'(GRID_Y0 + 3 * CELL_H);
   localparam logic [10:0] CW1    = 11'(CELL_W);
   localparam logic [10:0] CW2    = 11'(2 * CELL_W);
   localparam logic [10:0] CW3    = 11'(3 * CELL_W);
   localparam logic [10:0] CH1    = 11'(CELL_H);
   localparam logic [10:0] CH2    = 11'(2 * CELL_H);
   localparam logic [10:0] GXO    = 11'(GLYPH_XOFF);
   localparam logic [10:0] GYO    = 11'(GLYPH_YOFF);
   localparam logic [10:0] GX_END = 11'(GLYPH_XOFF + 48);
   localparam logic [10:0] GY_END = 11'(GLYPH_YOFF + 64);
   localparam logic [7:0]  WHITE  = {3'd7, 3'd7, 2'd3};
   localparam logic [7:0]  GREY   = {3'd1, 3'd1, 2'd1};
   localparam logic [7:0]  BLACK  = 8'h00;

   // Segment bits ordered {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg_map(input logic [3:0] d);
      case (d)
         4'h0:    seg_map = 7'b1111110;
         4'h1:    seg_map = 7'b0110000;
         4'h2:    seg_map = 7'b1101101;
         4'h3:    seg_map = 7'b1111001;
         4'h4:    seg_map = 7'b0110011;
         4'h5:    seg_map = 7'b1011011;
         4'h6:    seg_map = 7'b1011111;
         4'h7:    seg_map = 7'b1110000;
         4'h8:    seg_map = 7'b1111111;
         4'h9:    seg_map = 7'b1111011;
         4'hA:    seg_map = 7'b1110111;
         4'hB:    seg_map = 7'b0011111;
         4'hC:    seg_map = 7'b1001110;
         4'hD:    seg_map = 7'b0111101;
         4'hE:    seg_map = 7'b1001111;
         default: seg_map = 7'b1000111;
      endcase
   endfunction

   logic [10:0] px, py, rel_x, rel_y, cx, cy, gx, gy;
   logic [1:0]  col, row;
   logic [3:0]  k, digit;
   logic [3:0]  digits [12];
   logic [6:0]  seg_on, seg_hit;
   logic        active, in_grid, in_glyph, lit;
   logic        left, right, mid_x, top, upper, midb, lower, bot;

   assign px    = {1'b0, sx};
   assign py    = {1'b0, sy};
   assign rel_x = px - X0;
   assign rel_y = py - Y0;

   assign active  = (px < H_END) && (py < V_END);
   assign in_grid = (px >= X0) && (px < X_END) && (py >= Y0) && (py < Y_END);

   // Cell selection by compare-and-subtract; out-of-grid values are masked by in_grid
   always_comb begin
      col = 2'd0;
      cx  = rel_x;
      if (rel_x >= CW3) begin
         col = 2'd3;
         cx  = rel_x - CW3;
      end else if (rel_x >= CW2) begin
         col = 2'd2;
         cx  = rel_x - CW2;
      end else if (rel_x >= CW1) begin
         col = 2'd1;
         cx  = rel_x - CW1;
      end
      row = 2'd0;
      cy  = rel_y;
      if (rel_y >= CH2) begin
         row = 2'd2;
         cy  = rel_y - CH2;
      end else if (rel_y >= CH1) begin
         row = 2'd1;
         cy  = rel_y - CH1;
      end
   end

   always_comb begin
      for (int i = 0; i < 12; i++) begin
         digits[i] = numbers_concat[47 - 4 * i -: 4];
      end
   end

   // row*4 + col is just the concatenation
   assign k      = {row, col};
   assign digit  = digits[k];
   assign seg_on = seg_map(digit);

   assign gx       = cx - GXO;
   assign gy       = cy - GYO;
   assign in_glyph = (cx >= GXO) && (cx < GX_END) && (cy >= GYO) && (cy < GY_END);

   assign left  = (gx <= 11'd7);
   assign right = (gx >= 11'd40);
   assign mid_x = !left && !right;
   assign top   = (gy <= 11'd7);
   assign upper = (gy >= 11'd8)  && (gy <= 11'd27);
   assign midb  = (gy >= 11'd28) && (gy <= 11'd35);
   assign lower = (gy >= 11'd36) && (gy <= 11'd55);
   assign bot   = (gy >= 11'd56);

   assign seg_hit = {top & mid_x, right & upper, right & lower, bot & mid_x,
                     left & lower, left & upper, midb & mid_x};
   assign lit     = in_glyph && |(seg_hit & seg_on);

   always_ff @(posedge clk) begin
      if (rst) begin
         {vga_r, vga_g, vga_b} <= BLACK;
      end else if (!active || !in_grid) begin
         {vga_r, vga_g, vga_b} <= BLACK;
      end else if (lit) begin
         {vga_r, vga_g, vga_b} <= WHITE;
      end else begin
         {vga_r, vga_g, vga_b} <= GREY;
      end
   end

endmodule

// File: tb/tb_screen.sv
// Bench for screen: directed cases, a cell sweep and random pixels against a reference model.
module tb_screen;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  sx, sy;
   logic [47:0] numbers_concat;
   logic [2:0]  vga_r, vga_g;
   logic [1:0]  vga_b;

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] prev_exp = 8'h00;

   localparam logic [7:0] WHITE = 8'hFF;
   localparam logic [7:0] GREY  = 8'h25;

   string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
   string letters = "abcdefg";
   int rx0 [7] = '{8, 40, 40, 8, 0, 0, 8};
   int rx1 [7] = '{39, 47, 47, 39, 7, 7, 39};
   int ry0 [7] = '{0, 8, 36, 56, 36, 8, 28};
   int ry1 [7] = '{7, 27, 55, 63, 55, 27, 35};

   screen dut (
      .clk            (clk),
      .rst            (rst),
      .sx             (sx),
      .sy             (sy),
      .numbers_concat (numbers_concat),
      .vga_r          (vga_r),
      .vga_g          (vga_g),
      .vga_b          (vga_b)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_colour(input int x, input int y, input logic [47:0] n);
      int col, row, k, d, gx, gy;
      logic [47:0] sh;
      if (x >= 640 || y >= 480) return 8'h00;
      if (x < 160 || x >= 480 || y < 120 || y >= 360) return 8'h00;
      col = (x - 160) / 80;
      row = (y - 120) / 80;
      k   = row * 4 + col;
      sh  = n >> (44 - 4 * k);
      d   = int'(sh[3:0]);
      gx  = (x - 160) % 80 - 16;
      gy  = (y - 120) % 80 - 8;
      if (gx < 0 || gx >= 48 || gy < 0 || gy >= 64) return GREY;
      for (int s = 0; s < 7; s++) begin
         if (gx >= rx0[s] && gx <= rx1[s] && gy >= ry0[s] && gy <= ry1[s]) begin
            for (int c = 0; c < seg_names[d].len(); c++) begin
               if (seg_names[d].getc(c) == letters.getc(s)) return WHITE;
            end
         end
      end
      return GREY;
   endfunction

   task automatic check(input string tag, input logic [7:0] exp);
      vectors++;
      assert ({vga_r, vga_g, vga_b} === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed rgb=%h required rgb=%h (sx=%0d sy=%0d rst=%b)",
                tag, {vga_r, vga_g, vga_b}, exp, sx, sy, rst);
      end
   endtask

   // Drive at the falling edge, confirm the output still holds the previous
   // pixel, then check the new colour just after the rising edge.
   task automatic step(input string tag, input int x, input int y,
                       input logic [47:0] n, input logic r, input bit hold_chk);
      logic [7:0] exp;
      @(negedge clk);
      sx = 10'(x);
      sy = 10'(y);
      numbers_concat = n;
      rst = r;
      #1;
      if (hold_chk) check({tag, "_hold"}, prev_exp);
      exp = r ? 8'h00 : ref_colour(x, y, n);
      @(posedge clk);
      #1;
      check(tag, exp);
      prev_exp = exp;
   endtask

   initial begin
      logic [47:0] nums;
      int x, y;
      logic r;
      nums = 48'h0123456789AB;
      rst = 1'b1;
      sx = 10'd220;
      sy = 10'd140;
      numbers_concat = nums;

      for (int i = 0; i < 3; i++) step("reset", 220, 140, nums, 1'b1, 1'b0);
      step("release_seg_b", 220, 140, nums, 1'b0, 1'b1);
      check("release_is_white", WHITE);

      step("cell0_seg_g_unlit", 196, 159, nums, 1'b0, 1'b1);
      step("cell0_digit8_seg_g", 196, 159, 48'h8123456789AB, 1'b0, 1'b1);
      step("cell11_seg_f", 420, 300, nums, 1'b0, 1'b1);
      step("cell11_seg_a_unlit", 436, 291, nums, 1'b0, 1'b1);
      step("outside_grid", 100, 100, nums, 1'b0, 1'b1);
      step("hblank", 650, 140, nums, 1'b0, 1'b1);
      step("below_grid", 220, 479, nums, 1'b0, 1'b1);
      step("vblank", 220, 480, nums, 1'b0, 1'b1);
      step("max_coord", 1023, 1023, nums, 1'b0, 1'b1);
      step("left_of_grid", 159, 140, nums, 1'b0, 1'b1);

      for (int xs = 160; xs <= 480; xs++) step("sweep_y140", xs, 140, nums, 1'b0, 1'b1);
      for (int ys = 118; ys <= 362; ys++) step("sweep_x220", 220, ys, 48'hFEDCBA987654, 1'b0, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         if (i % 16 == 0) nums = {$urandom, $urandom_range(0, 65535)};
         if ($urandom_range(0, 3) == 0) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
         end else begin
            x = $urandom_range(150, 490);
            y = $urandom_range(110, 370);
         end
         r = ($urandom_range(0, 31) == 0);
         step("random", x, y, nums, r, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
